// File: rtl/pe_array_driver_if.sv
// rtl/pe_array_driver_if.sv - weight/activation/result streams and PE array side-band for pe_array_driver
interface pe_array_driver_if #(
  parameter int W = 8,
  parameter int N = 16
);
  logic             w_valid;
  logic             w_ready;
  logic [N*W-1:0]   w_data;

  logic             x_valid;
  logic             x_ready;
  logic [N*W-1:0]   x_data;
  logic             x_last;

  logic             y_valid;
  logic             y_ready;
  logic [N*2*W-1:0] y_data;
  logic             y_last;

  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic             stationaryCtrl;
  logic [N*2*W-1:0] c_out;
  logic             busy;

  modport slave (
    input  w_valid, w_data, x_valid, x_data, x_last, y_ready, c_out,
    output w_ready, x_ready, y_valid, y_data, y_last, a_in, b_in, stationaryCtrl, busy
  );

  modport master (
    output w_valid, w_data, x_valid, x_data, x_last, y_ready, c_out,
    input  w_ready, x_ready, y_valid, y_data, y_last, a_in, b_in, stationaryCtrl, busy
  );
endinterface

// File: rtl/pe_array_driver.sv
// rtl/pe_array_driver.sv - loads stationary weights, streams activations and collects row sums of the PE array
module pe_array_driver #(
  parameter int W         = 8,
  parameter int N         = 16,
  parameter int PE_LAT    = 1,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  pe_array_driver_if.slave bus
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + PE_LAT + 1) + 1;
  localparam int LW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    st_idle,
    st_load,
    st_settle,
    st_stream,
    st_drain
  } state_t;

  state_t state, state_nx;

  logic [LW-1:0]      ld_cnt;
  logic [PE_LAT-1:0]  tag_v;
  logic [PE_LAT-1:0]  tag_l;
  logic [N*2*W-1:0]   mem [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] mem_l;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      occ;
  logic [CW-1:0]      inflight;
  logic               w_acc;
  logic               x_acc;
  logic               push;
  logic               pop;
  logic               credit;
  logic               y_vld;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PE_LAT; i++) begin
      inflight = inflight + CW'(tag_v[i]);
    end
  end

  // Every accepted activation reserves a FIFO slot up front, so an emerging tag always finds room.
  assign credit = (occ + inflight) < CW'(OUT_DEPTH);
  assign push   = tag_v[PE_LAT-1];
  assign y_vld  = (occ != '0);
  assign pop    = y_vld & bus.y_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_idle;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx           = state;
    w_acc              = 1'b0;
    x_acc              = 1'b0;
    bus.w_ready        = 1'b0;
    bus.x_ready        = 1'b0;
    bus.a_in           = '0;
    bus.b_in           = '0;
    bus.stationaryCtrl = 1'b0;
    bus.busy           = (state != st_idle);
    case (state)
      st_idle: begin
        if (bus.w_valid) begin
          state_nx = st_load;
        end
      end
      st_load: begin
        bus.w_ready = 1'b1;
        w_acc       = bus.w_valid;
        if (w_acc) begin
          bus.a_in           = bus.w_data;
          bus.stationaryCtrl = 1'b1;
          if (ld_cnt == LW'(N - 1)) begin
            state_nx = st_settle;
          end
        end
      end
      st_settle: begin
        state_nx = st_stream;
      end
      st_stream: begin
        bus.x_ready = credit;
        x_acc       = bus.x_valid & credit;
        if (x_acc) begin
          bus.b_in = bus.x_data;
          if (bus.x_last) begin
            state_nx = st_drain;
          end
        end
      end
      st_drain: begin
        if ((inflight == '0) && (occ == '0)) begin
          state_nx = st_idle;
        end
      end
      default: begin
        state_nx = st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt <= '0;
      tag_v  <= '0;
      tag_l  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (w_acc) begin
        ld_cnt <= (ld_cnt == LW'(N - 1)) ? '0 : ld_cnt + LW'(1);
      end

      // Tag pipe mirrors the array latency so c_out is captured exactly when its vector emerges.
      for (int i = PE_LAT - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
      tag_v[0] <= x_acc;
      tag_l[0] <= x_acc & bus.x_last;

      if (push) begin
        wr_ptr <= (wr_ptr == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]   <= bus.c_out;
      mem_l[wr_ptr] <= tag_l[PE_LAT-1];
    end
  end

  // Storage is not reset; gating keeps the result bus at zero whenever nothing is offered.
  assign bus.y_valid = y_vld;
  assign bus.y_data  = y_vld ? mem[rd_ptr] : '0;
  assign bus.y_last  = y_vld ? mem_l[rd_ptr] : 1'b0;

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (occ == CW'(OUT_DEPTH))));

endmodule

// File: tb/tb_pe_array_driver.sv
// tb/tb_pe_array_driver.sv - randomized bench with behavioural PE array and result reference model
module tb_pe_array_driver;

  localparam int W         = 8;
  localparam int N         = 16;
  localparam int PE_LAT    = 1;
  localparam int OUT_DEPTH = 4;
  localparam int CKW       = N*2*W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pe_array_driver_if #(.W(W), .N(N)) bus ();

  pe_array_driver #(.W(W), .N(N), .PE_LAT(PE_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [CKW-1:0] got, input logic [CKW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural PE array: shifting weight rows, PE_LAT-deep row-sum output.
  logic signed [W-1:0] arr [N][N];
  logic [N*2*W-1:0]    cpipe [PE_LAT];
  assign bus.c_out = cpipe[PE_LAT-1];

  function automatic logic [N*2*W-1:0] array_sum(input logic [N*W-1:0] b);
    logic [N*2*W-1:0] r;
    int acc;
    for (int i = 0; i < N; i++) begin
      acc = 0;
      for (int j = 0; j < N; j++) acc += int'(arr[i][j]) * int'($signed(b[j*W +: W]));
      r[i*2*W +: 2*W] = acc[2*W-1:0];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.stationaryCtrl) begin
      for (int r = N-1; r > 0; r--) arr[r] <= arr[r-1];
      for (int j = 0; j < N; j++) arr[0][j] <= $signed(bus.a_in[j*W +: W]);
    end
    cpipe[0] <= array_sum(bus.b_in);
    for (int k = 1; k < PE_LAT; k++) cpipe[k] <= cpipe[k-1];
  end

  // Reference: beat k holds array row N-1-k, so row i comes from beat N-1-i.
  logic [N*W-1:0] wbeats [N];

  function automatic logic [N*2*W-1:0] ref_y(input logic [N*W-1:0] x);
    logic [N*2*W-1:0] r;
    logic [N*W-1:0]   row;
    int acc;
    for (int i = 0; i < N; i++) begin
      row = wbeats[N-1-i];
      acc = 0;
      for (int j = 0; j < N; j++) acc += int'($signed(row[j*W +: W])) * int'($signed(x[j*W +: W]));
      r[i*2*W +: 2*W] = acc[2*W-1:0];
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] rnd_vec();
    logic [N*W-1:0] v;
    for (int j = 0; j < N; j++) v[j*W +: W] = W'($urandom);
    return v;
  endfunction

  logic [N*2*W:0]   exp_q [$];
  logic [N*2*W:0]   held;
  logic [N*2*W-1:0] last_y;
  logic             last_ylast;
  bit  hold_pending = 0, lat_arm = 0, stream_chk = 0, pend_acc = 0, pend_pop = 0;
  int  y_beats = 0, sc_pulses = 0, xr_drop = 0, cyc = 0, acc_cyc = 0, outstanding = 0, yr_mode = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) outstanding = 0;
    else outstanding = outstanding + int'(pend_acc) - int'(pend_pop);
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      hold_pending = 0; pend_acc = 0; pend_pop = 0;
    end else begin
      if (bus.stationaryCtrl) sc_pulses++;
      if (hold_pending) chk("y_hold", {bus.y_valid, bus.y_last, bus.y_data}, {1'b1, held});
      if (lat_arm && bus.y_valid) begin
        chk("y_latency", cyc - acc_cyc, PE_LAT + 1);
        lat_arm = 0;
      end
      if (stream_chk) chk("x_ready_credit", bus.x_ready, outstanding < OUT_DEPTH);
      if (stream_chk && bus.x_valid && !bus.x_ready) xr_drop++;
      if (bus.y_valid && bus.y_ready) begin
        y_beats++;
        last_y = bus.y_data;
        last_ylast = bus.y_last;
        if (exp_q.size() == 0) chk("y_unexpected", bus.y_valid, 0);
        else chk("y_beat", {bus.y_last, bus.y_data}, exp_q.pop_front());
      end
      hold_pending = bus.y_valid && !bus.y_ready;
      held = {bus.y_last, bus.y_data};
      pend_acc = bus.x_valid && bus.x_ready;
      pend_pop = bus.y_valid && bus.y_ready;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (yr_mode == 1) bus.y_ready = ~bus.y_ready;
    else if (yr_mode == 2) bus.y_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_w(input logic [N*W-1:0] d);
    int t = 0;
    bus.w_valid = 1'b1;
    bus.w_data  = d;
    @(negedge clk);
    while (!bus.w_ready && t < 100) begin @(negedge clk); t++; end
    chk("w_accept", bus.w_ready, 1);
    @(posedge clk); #1;
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
  endtask

  task automatic load_weights(input int gap);
    for (int k = 0; k < N; k++) begin
      if (k > 0) cycles(gap);
      send_w(wbeats[k]);
    end
  endtask

  task automatic send_x(input logic [N*W-1:0] d, input bit last, input bit probe);
    int t = 0;
    bus.x_valid = 1'b1;
    bus.x_data  = d;
    bus.x_last  = last;
    @(negedge clk);
    while (!bus.x_ready && t < 200) begin @(negedge clk); t++; end
    chk("x_accept", bus.x_ready, 1);
    if (bus.x_ready) begin
      exp_q.push_back({last, ref_y(d)});
      acc_cyc = cyc;
      if (probe) lat_arm = 1;
    end
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
    bus.x_last  = 1'b0;
    bus.x_data  = '0;
    if (last) stream_chk = 0;
  endtask

  task automatic run_stream(input int n);
    cycles(1);
    stream_chk = 1;
    for (int i = 0; i < n; i++) send_x(rnd_vec(), i == n-1, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (bus.busy && t < 500) begin @(negedge clk); t++; end
    chk("idle", bus.busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic rnd_weights();
    for (int k = 0; k < N; k++) wbeats[k] = rnd_vec();
  endtask

  initial begin
    logic [N*W-1:0]   xv;
    logic [N*2*W-1:0] ye;
    int beats0;
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N*W-1:0]   xv;
    logic [N*2*W-1:0] ye;
    int beats0;
    bus.w_valid = 0; bus.w_data = '0;
    bus.x_valid = 0; bus.x_data = '0; bus.x_last = 0;
    bus.y_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {bus.w_ready, bus.x_ready, bus.y_valid, bus.y_last, bus.stationaryCtrl, bus.busy}, 0);
    chk("rst_ydata", bus.y_data, 0);
    chk("rst_ab", {bus.a_in, bus.b_in}, 0);
    @(posedge clk); #1;
    rst = 0;

    // identity weights, x = 1..16
    for (int k = 0; k < N; k++) begin
      wbeats[k] = '0;
      wbeats[k][(N-1-k)*W +: W] = W'(1);
    end
    load_weights(0);
    bus.y_ready = 1;
    for (int j = 0; j < N; j++) xv[j*W +: W] = W'(j + 1);
    cycles(1);
    stream_chk = 1;
    send_x(xv, 1, 1);
    wait_idle();
    for (int i = 0; i < N; i++) ye[i*2*W +: 2*W] = 16'(i + 1);
    chk("identity_y", last_y, ye);
    chk("identity_last", last_ylast, 1);

    // extremes wrap to zero
    for (int k = 0; k < N; k++) wbeats[k] = {N{8'h80}};
    load_weights(0);
    cycles(1);
    stream_chk = 1;
    send_x({N{8'h80}}, 1, 0);
    wait_idle();
    chk("extreme_y", last_y, 0);

    // load with 3-cycle gaps
    rnd_weights();
    sc_pulses = 0;
    load_weights(3);
    chk("sc_pulses", sc_pulses, N);
    run_stream(6);
    wait_idle();

    // backpressure: y_ready toggling
    rnd_weights();
    load_weights(0);
    beats0 = y_beats; xr_drop = 0; yr_mode = 1;
    run_stream(10);
    wait_idle();
    yr_mode = 0; bus.y_ready = 1;
    chk("bp_count", y_beats - beats0, 10);
    chk("bp_xready_drop", xr_drop > 0, 1);
    chk("bp_q_empty", exp_q.size(), 0);

    // random y_ready
    rnd_weights();
    load_weights($urandom_range(0, 2));
    yr_mode = 2;
    run_stream(20);
    wait_idle();
    yr_mode = 0; bus.y_ready = 1;
    chk("rnd_q_empty", exp_q.size(), 0);

    // single-vector job
    rnd_weights();
    load_weights(0);
    beats0 = y_beats;
    run_stream(1);
    wait_idle();
    chk("single_count", y_beats - beats0, 1);
    chk("single_last", last_ylast, 1);

    // reset mid-stream with results pending
    rnd_weights();
    load_weights(0);
    bus.y_ready = 0;
    cycles(1);
    stream_chk = 1;
    for (int i = 0; i < 3; i++) send_x(rnd_vec(), 0, 0);
    stream_chk = 0;
    @(negedge clk);
    chk("pre_rst_yvalid", bus.y_valid, 1);
    @(posedge clk); #1;
    rst = 1;
    exp_q.delete();
    beats0 = y_beats;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ctrl", {bus.w_ready, bus.x_ready, bus.y_valid, bus.y_last, bus.stationaryCtrl, bus.busy}, 0);
    chk("mid_rst_ydata", bus.y_data, 0);
    @(posedge clk); #1;
    rst = 0;
    bus.y_ready = 1;
    cycles(10);
    chk("rst_no_y", y_beats - beats0, 0);
    chk("rst_busy", bus.busy, 0);

    // recovery job after reset
    rnd_weights();
    load_weights(1);
    run_stream(3);
    wait_idle();
    chk("recover_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
